// File: rtl/scroll_pkg.sv
// Shared constants for the scroll controller: position count, code limits,
// run/stop encoding and the rotation-code successor function.
package scroll_pkg;

  localparam int          NUM_POS = 6;
  localparam int          C_W     = 3;
  localparam logic [2:0]  C_MAX   = 3'd5;

  localparam logic [0:0]  ST_STOP = 1'b0;
  localparam logic [0:0]  ST_RUN  = 1'b1;

  // Successor of a rotation code; codes above C_MAX recover to 0 in either direction.
  function automatic logic [C_W-1:0] next_pos(input logic [C_W-1:0] c, input logic dir);
    logic [C_W-1:0] n;
    if (c > C_MAX)      n = '0;
    else if (!dir)      n = (c == C_MAX) ? '0 : c + 3'd1;
    else                n = (c == '0) ? C_MAX : c - 3'd1;
    return n;
  endfunction

endpackage

// File: rtl/key_sync.sv
// Three-flop synchronizer for the active-low pushbutton plus a falling-edge
// detector; press is high for one cycle per button press, however long held.
module key_sync (
  input  logic Clock,
  input  logic Resetn,
  input  logic key_n,
  output logic press
);

  logic s1_q, s2_q, s3_q;

  // Shift the raw key through three flops; idle (released) level is 1.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= key_n;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Falling edge seen between the last two stages.
  assign press = s3_q & ~s2_q;

endmodule

// File: rtl/scroll_ctrl.sv
// Scroll controller: a pushbutton toggles RUN/STOP; while running, a prescaler
// advances the 6-position rotation code C every L = max(DIV >> Speed, 1) cycles.
module scroll_ctrl
  import scroll_pkg::*;
#(
  parameter int DIV = 50_000_000
) (
  input  logic           Clock,
  input  logic           Resetn,
  input  logic           Start_n,
  input  logic           Dir,
  input  logic [1:0]     Speed,
  output logic [C_W-1:0] C,
  output logic           Step,
  output logic           Running
);

  localparam int PW = $clog2(DIV);

  logic           press;
  logic [0:0]     state_q, state_d;
  logic [PW-1:0]  p_q, p_d;
  logic [C_W-1:0] c_q, c_d;
  logic           step_q, step_d;
  logic [31:0]    lim_w;
  logic [PW-1:0]  lim_m1;

  key_sync u_key_sync (
    .Clock  (Clock),
    .Resetn (Resetn),
    .key_n  (Start_n),
    .press  (press)
  );

  // Step limit minus one; L never drops below 1 so the subtraction cannot wrap.
  always_comb begin
    lim_w = 32'(DIV) >> Speed;
    if (lim_w == 32'd0) lim_w = 32'd1;
    lim_m1 = PW'(lim_w - 32'd1);
  end

  // Next-state: a press always wins over a coincident step; the >= compare
  // lets a mid-count speed-up step on the next edge instead of wrapping P.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    c_d     = c_q;
    step_d  = 1'b0;
    if (press) begin
      state_d = (state_q == ST_RUN) ? ST_STOP : ST_RUN;
      p_d     = '0;
    end else if (state_q == ST_RUN) begin
      if (p_q >= lim_m1) begin
        p_d    = '0;
        c_d    = next_pos(c_q, Dir);
        step_d = 1'b1;
      end else begin
        p_d = p_q + 1'b1;
      end
    end else begin
      p_d = '0;
    end
  end

  // State, prescaler, rotation code and step pulse registers.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_STOP;
      p_q     <= '0;
      c_q     <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      c_q     <= c_d;
      step_q  <= step_d;
    end
  end

  assign C       = c_q;
  assign Step    = step_q;
  assign Running = (state_q == ST_RUN);

endmodule

// File: tb/tb_scroll_ctrl.sv
// Directed self-checking bench for scroll_ctrl with DIV=8.
module tb_scroll_ctrl;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic       Start_n;
  logic       Dir;
  logic [1:0] Speed;
  logic [2:0] C;
  logic       Step;
  logic       Running;

  int errors = 0;
  int checks = 0;

  scroll_ctrl #(.DIV(8)) dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .Start_n (Start_n),
    .Dir     (Dir),
    .Speed   (Speed),
    .C       (C),
    .Step    (Step),
    .Running (Running)
  );

  always #5 Clock = ~Clock;

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic test_reset();
    Resetn = 1'b0; Start_n = 1'b1; Dir = 1'b0; Speed = 2'd0;
    #1;
    checks++; if (Running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b want 0", Running); end
    checks++; if (C !== 3'd0) begin errors++; $display("FAIL reset_c: got %0d want 0", C); end
    checks++; if (Step !== 1'b0) begin errors++; $display("FAIL reset_step: got %b want 0", Step); end
    tick(2);
    #2 Resetn = 1'b1;
    tick(3);
    checks++; if (Running !== 1'b0 || C !== 3'd0) begin errors++; $display("FAIL reset_idle: got run=%b C=%0d want run=0 C=0", Running, C); end
  endtask

  // Press with Dir=0, Speed=0: run 3 edges later, steps every 8 cycles.
  task automatic test_basic();
    int nsteps;
    Start_n = 1'b0;
    tick(2);
    checks++; if (Running !== 1'b0) begin errors++; $display("FAIL basic_early: got run=%b want 0", Running); end
    tick(1);
    checks++; if (Running !== 1'b1) begin errors++; $display("FAIL basic_run: got run=%b want 1", Running); end
    Start_n = 1'b1;
    tick(7);
    checks++; if (C !== 3'd0 || Step !== 1'b0) begin errors++; $display("FAIL basic_pre: got C=%0d step=%b want C=0 step=0", C, Step); end
    tick(1);
    checks++; if (C !== 3'd1 || Step !== 1'b1) begin errors++; $display("FAIL basic_first: got C=%0d step=%b want C=1 step=1", C, Step); end
    tick(1);
    checks++; if (C !== 3'd1 || Step !== 1'b0) begin errors++; $display("FAIL basic_pulse: got C=%0d step=%b want C=1 step=0", C, Step); end
    tick(7);
    checks++; if (C !== 3'd2 || Step !== 1'b1) begin errors++; $display("FAIL basic_second: got C=%0d step=%b want C=2 step=1", C, Step); end
    nsteps = 0;
    for (int i = 0; i < 24; i++) begin
      tick(1);
      if (Step === 1'b1) nsteps++;
    end
    checks++; if (nsteps != 3 || C !== 3'd5) begin errors++; $display("FAIL basic_count: got steps=%0d C=%0d want steps=3 C=5", nsteps, C); end
  endtask

  // Wrap 5->0 going up, then reverse: 0->5->4.
  task automatic test_wrap_dir();
    tick(8);
    checks++; if (C !== 3'd0) begin errors++; $display("FAIL wrap_up: got C=%0d want 0", C); end
    Dir = 1'b1;
    tick(8);
    checks++; if (C !== 3'd5) begin errors++; $display("FAIL wrap_down: got C=%0d want 5", C); end
    tick(8);
    checks++; if (C !== 3'd4) begin errors++; $display("FAIL dir_down: got C=%0d want 4", C); end
  endtask

  // L=1 steps every cycle; slowing at P=0 gives 8 cycles; speeding up at P=5 steps next edge.
  task automatic test_speed();
    logic [2:0] exp_c;
    Speed = 2'd3;
    exp_c = 3'd4;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      exp_c = exp_c - 3'd1;
      checks++; if (C !== exp_c || Step !== 1'b1) begin errors++; $display("FAIL speed3_%0d: got C=%0d step=%b want C=%0d step=1", i, C, Step, exp_c); end
    end
    Speed = 2'd0;
    tick(7);
    checks++; if (C !== 3'd0) begin errors++; $display("FAIL speed0_hold: got C=%0d want 0", C); end
    tick(1);
    checks++; if (C !== 3'd5 || Step !== 1'b1) begin errors++; $display("FAIL speed0_step: got C=%0d step=%b want C=5 step=1", C, Step); end
    tick(5);
    checks++; if (C !== 3'd5) begin errors++; $display("FAIL speed_p5: got C=%0d want 5", C); end
    Speed = 2'd2;
    tick(1);
    checks++; if (C !== 3'd4 || Step !== 1'b1) begin errors++; $display("FAIL speed2_fast: got C=%0d step=%b want C=4 step=1", C, Step); end
    Speed = 2'd0;
  endtask

  // Held button toggles once; stop at C=3 holds; press on a step edge blocks the step.
  task automatic test_press();
    int toggles;
    logic prev;
    Start_n = 1'b0;
    toggles = 0;
    prev = Running;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (Running !== prev) toggles++;
      prev = Running;
    end
    checks++; if (toggles != 1 || Running !== 1'b0 || C !== 3'd4) begin errors++; $display("FAIL hold_once: got toggles=%0d run=%b C=%0d want 1 0 4", toggles, Running, C); end
    Start_n = 1'b1;
    tick(5);
    Start_n = 1'b0;
    tick(3);
    checks++; if (Running !== 1'b1) begin errors++; $display("FAIL resume_run: got run=%b want 1", Running); end
    Start_n = 1'b1;
    tick(8);
    checks++; if (C !== 3'd3 || Step !== 1'b1) begin errors++; $display("FAIL resume_step: got C=%0d step=%b want C=3 step=1", C, Step); end
    Start_n = 1'b0;
    tick(3);
    checks++; if (Running !== 1'b0 || C !== 3'd3) begin errors++; $display("FAIL stop_at3: got run=%b C=%0d want 0 3", Running, C); end
    Start_n = 1'b1;
    tick(20);
    checks++; if (C !== 3'd3 || Step !== 1'b0) begin errors++; $display("FAIL stop_hold: got C=%0d step=%b want C=3 step=0", C, Step); end
    Start_n = 1'b0;
    tick(3);
    checks++; if (Running !== 1'b1) begin errors++; $display("FAIL coin_run: got run=%b want 1", Running); end
    Start_n = 1'b1;
    tick(5);
    Start_n = 1'b0;
    tick(2);
    checks++; if (Running !== 1'b1 || C !== 3'd3) begin errors++; $display("FAIL coin_pre: got run=%b C=%0d want 1 3", Running, C); end
    tick(1);
    checks++; if (Running !== 1'b0 || C !== 3'd3 || Step !== 1'b0) begin errors++; $display("FAIL coin_stop: got run=%b C=%0d step=%b want 0 3 0", Running, C, Step); end
    Start_n = 1'b1;
    tick(10);
    checks++; if (C !== 3'd3 || Step !== 1'b0) begin errors++; $display("FAIL coin_hold: got C=%0d step=%b want C=3 step=0", C, Step); end
  endtask

  // Reset at P=6, C=4 with a press in flight; afterwards no activity until a press.
  task automatic test_reset_mid();
    int nsteps;
    Dir = 1'b0;
    Start_n = 1'b0;
    tick(3);
    checks++; if (Running !== 1'b1) begin errors++; $display("FAIL mid_run: got run=%b want 1", Running); end
    Start_n = 1'b1;
    tick(8);
    checks++; if (C !== 3'd4) begin errors++; $display("FAIL mid_c4: got C=%0d want 4", C); end
    tick(5);
    Start_n = 1'b0;
    tick(1);
    checks++; if (C !== 3'd4 || Running !== 1'b1) begin errors++; $display("FAIL mid_pre: got C=%0d run=%b want 4 1", C, Running); end
    Resetn = 1'b0;
    #1;
    checks++; if (C !== 3'd0 || Running !== 1'b0 || Step !== 1'b0) begin errors++; $display("FAIL mid_async: got C=%0d run=%b step=%b want 0 0 0", C, Running, Step); end
    tick(2);
    Start_n = 1'b1;
    #2 Resetn = 1'b1;
    nsteps = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (Step === 1'b1 || Running === 1'b1) nsteps++;
    end
    checks++; if (nsteps != 0 || C !== 3'd0) begin errors++; $display("FAIL mid_quiet: got active=%0d C=%0d want 0 0", nsteps, C); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap_dir();
    test_speed();
    test_press();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scroll_ctrl.md
SCROLL_CTRL -- requirements
Module: scroll_ctrl

Interface
REQ-001 Parameter DIV, default 50_000_000, is the base number of Clock cycles per scroll step; legal range is DIV >= 8.
REQ-002 Port Clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port Resetn, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port Start_n, input, 1 bit: asynchronous active-low pushbutton; each press toggles run/stop.
REQ-005 Port Dir, input, 1 bit: 0 = C increments, 1 = C decrements.
REQ-006 Port Speed, input, 2 bits: step-rate select.
REQ-007 Port C, output, 3 bits: rotation code for the 6-position message decoder; legal values are 0..5.
REQ-008 Port Step, output, 1 bit: one-cycle pulse in the first cycle a new C value is presented.
REQ-009 Port Running, output, 1 bit: 1 in RUN, 0 in STOP.

Function
REQ-010 Start_n SHALL pass through a 3-flop synchronizer (s1, s2, s3); press = s3 high and s2 low.
REQ-011 A press SHALL toggle the state on the 3rd rising Clock edge after Start_n is first sampled low; holding the button SHALL produce one toggle only.
REQ-012 The FSM has two states, STOP and RUN: press in STOP -> RUN; press in RUN -> STOP; otherwise the state holds.
REQ-013 Step limit L SHALL be DIV >> Speed, floored at 1; L is re-evaluated every cycle.
REQ-014 In STOP, prescaler P SHALL be held at 0, C SHALL hold its value and Step SHALL be 0.
REQ-015 In RUN, P SHALL increment by 1 each cycle while P < L-1.
REQ-016 In RUN, on the edge where P >= L-1: P <= 0, C <= next(C), and Step <= 1 for exactly one cycle.
REQ-017 The first C change after entering RUN SHALL occur L cycles after Running rises, then every L cycles.
REQ-018 next(C) with Dir=0: 0->1->2->3->4->5->0.
REQ-019 next(C) with Dir=1: 5->4->3->2->1->0->5.
REQ-020 An illegal C (6 or 7) SHALL map to 0 on the next step in either direction.
REQ-021 If Speed changes mid-count so that P >= L-1, the step SHALL occur on the next edge (no wrap through 2^N).
REQ-022 A Dir change SHALL affect only steps taken after it; P is not reset.
REQ-023 If a press toggling RUN->STOP coincides with a step edge, STOP wins: C does not change, Step stays 0, and P <= 0.
REQ-024 Re-entering RUN SHALL resume from the held C value.
REQ-025 The P width SHALL be $clog2(DIV); comparisons SHALL be unsigned.

Reset
REQ-026 Resetn low SHALL immediately force STOP, P=0, C=0, Step=0, Running=0, and s1/s2/s3 = 1.
REQ-027 Reset asserted mid-count or mid-press SHALL discard all progress; after release the block waits in STOP for a fresh press.

Structure
REQ-028 Shared package scroll_pkg SHALL hold NUM_POS=6, the C_MAX=5 constant and the STOP/RUN state encoding.
REQ-029 The synchronizer and falling-edge detector SHALL be one sub-module, key_sync (ports Clock, Resetn, key_n, press).
REQ-030 All outputs SHALL be registered; none may be combinational from inputs.

Verification (DIV=8 unless noted)
REQ-031 Reset, then a press with Dir=0 and Speed=0 -> Running=1 three edges later; C steps 0->1 after 8 cycles, then every 8 cycles; Step pulses once per change.
REQ-032 Run from C=5 with Dir=0 -> C wraps to 0; then set Dir=1 -> C goes 0->5->4.
REQ-033 Speed=3 (L=1) -> C changes every cycle; switch to Speed=0 when P=0 -> next step 8 cycles later; switch Speed 0->2 when P=5 -> step on the next edge.
REQ-034 Hold Start_n low for 100 cycles -> exactly one toggle; press again at C=3 -> STOP with C held at 3; press timed to coincide with a step -> no C change.
REQ-035 Assert Resetn at P=6, C=4 -> C=0, Running=0 asynchronously; after release there are no steps until a press.
